// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, types and round helper functions.
package sha256_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD   = 4'd1,
        ST_ROUND  = 4'd2,
        ST_FINAL  = 4'd3,
        ST_LOAD2  = 4'd4,
        ST_ROUND2 = 4'd5,
        ST_FINAL2 = 4'd6,
        ST_OUT    = 4'd7,
        ST_DONE   = 4'd8
    } state_t;

    // Message schedule window; index 0 is the oldest word.
    typedef logic [15:0][31:0] sched_win_t;

    localparam logic [255:0] SHA_IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [31:0] PAD_WORD   = 32'h8000_0000;
    localparam logic [31:0] LEN_HEADER = 32'h0000_0280;  // 640-bit header
    localparam logic [31:0] LEN_DIGEST = 32'h0000_0100;  // 256-bit digest

    localparam logic [31:0] SHA_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        logic [63:0] xx;
        xx = {x, x} >> n;
        return xx[31:0];
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // Word-wise modulo-2^32 addition of two 8-word states.
    function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
        end
        return r;
    endfunction

    // Second header block: tail words, nonce, padding and 640-bit length.
    function automatic sched_win_t build_block2(input logic [95:0] tl, input logic [31:0] nonce);
        sched_win_t b;
        b     = '0;
        b[0]  = tl[95:64];
        b[1]  = tl[63:32];
        b[2]  = tl[31:0];
        b[3]  = nonce;
        b[4]  = PAD_WORD;
        b[15] = LEN_HEADER;
        return b;
    endfunction

    // Block hashing a 256-bit digest once more (H0 first).
    function automatic sched_win_t build_block_dh(input logic [255:0] d);
        sched_win_t b;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            b[i] = d[255 - 32*i -: 32];
        end
        b[8]  = PAD_WORD;
        b[15] = LEN_DIGEST;
        return b;
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One SHA-256 compression round plus one sliding-window schedule step.
// For rounds 0..15 the window is rotated so that after 16 rounds it holds
// W[0..15] in order; from round 16 on W[t] is computed from it and consumed
// in the same cycle.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] wv,
    input  sched_win_t   win,
    input  logic [31:0]  k,
    input  logic         sched_en,
    output logic [255:0] wv_next,
    output sched_win_t   win_next
);

    logic [31:0] a_s, b_s, c_s, d_s, e_s, f_s, g_s, h_s;
    logic [31:0] wt_s, t1_s, t2_s;

    assign {a_s, b_s, c_s, d_s, e_s, f_s, g_s, h_s} = wv;

    // Select W[t], then compute the round and shift the schedule window.
    always_comb begin
        wt_s = 32'd0;
        if (sched_en) begin
            wt_s = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];
        end else begin
            wt_s = win[0];
        end
        t1_s     = h_s + big_sigma1(e_s) + ch(e_s, f_s, g_s) + k + wt_s;
        t2_s     = big_sigma0(a_s) + maj(a_s, b_s, c_s);
        wv_next  = {t1_s + t2_s, a_s, b_s, c_s, d_s + t1_s, e_s, f_s, g_s};
        win_next = {wt_s, win[15:1]};
    end

endmodule

// File: rtl/sha256_nonce_sweep.sv
// Hashes NUM_NONCES consecutive nonces of a block header (second block plus
// optional SHA-256d pass), one round per cycle, with a valid/ready result port.
// midstate and out_hash carry H0 in bits [255:224]; tail carries W0 in [95:64].
module sha256_nonce_sweep
    import sha256_pkg::*;
#(
    parameter int NUM_NONCES  = 16,
    parameter int DOUBLE_HASH = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [255:0] midstate,
    input  logic [95:0]  tail,
    input  logic [31:0]  nonce_base,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_nonce,
    output logic [255:0] out_hash,
    output logic         done
);

    localparam logic [16:0] LAST_CNT = 17'(NUM_NONCES - 1);

    state_t       state_r;
    logic [5:0]   round_r;
    logic [16:0]  remain_r;
    logic [255:0] mid_r;
    logic [95:0]  tail_r;
    logic [31:0]  nonce_r;
    logic [255:0] chain_r;
    logic [255:0] wv_r;
    sched_win_t   win_r;
    logic         busy_r;
    logic         out_valid_r;
    logic         done_r;
    logic [31:0]  out_nonce_r;
    logic [255:0] out_hash_r;

    logic         sched_en_s;
    logic [31:0]  k_s;
    logic [255:0] wv_next_s;
    sched_win_t   win_next_s;
    logic [255:0] digest_s;

    assign sched_en_s = (round_r >= 6'd16);
    assign k_s        = SHA_K[round_r];
    assign digest_s   = add_words(wv_r, chain_r);

    sha256_round u_round (
        .wv       (wv_r),
        .win      (win_r),
        .k        (k_s),
        .sched_en (sched_en_s),
        .wv_next  (wv_next_s),
        .win_next (win_next_s)
    );

    // Sweep controller: state, working variables, schedule and outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            round_r     <= 6'd0;
            remain_r    <= 17'd0;
            mid_r       <= 256'd0;
            tail_r      <= 96'd0;
            nonce_r     <= 32'd0;
            chain_r     <= 256'd0;
            wv_r        <= 256'd0;
            win_r       <= '0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
            out_nonce_r <= 32'd0;
            out_hash_r  <= 256'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        mid_r    <= midstate;
                        tail_r   <= tail;
                        nonce_r  <= nonce_base;
                        remain_r <= LAST_CNT;
                        busy_r   <= 1'b1;
                        state_r  <= ST_LOAD;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    chain_r <= mid_r;
                    wv_r    <= mid_r;
                    win_r   <= build_block2(tail_r, nonce_r);
                    round_r <= 6'd0;
                    state_r <= ST_ROUND;
                end
                ST_ROUND, ST_ROUND2: begin
                    wv_r    <= wv_next_s;
                    win_r   <= win_next_s;
                    round_r <= round_r + 6'd1;
                    if (round_r == 6'd63) begin
                        state_r <= (state_r == ST_ROUND) ? ST_FINAL : ST_FINAL2;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_FINAL: begin
                    // The pass-1 digest is parked in out_hash_r while out_valid is low.
                    out_hash_r <= digest_s;
                    if (DOUBLE_HASH != 0) begin
                        state_r <= ST_LOAD2;
                    end else begin
                        out_nonce_r <= nonce_r;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_OUT;
                    end
                end
                ST_LOAD2: begin
                    chain_r <= SHA_IV;
                    wv_r    <= SHA_IV;
                    win_r   <= build_block_dh(out_hash_r);
                    round_r <= 6'd0;
                    state_r <= ST_ROUND2;
                end
                ST_FINAL2: begin
                    out_hash_r  <= digest_s;
                    out_nonce_r <= nonce_r;
                    out_valid_r <= 1'b1;
                    state_r     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        if (remain_r != 17'd0) begin
                            remain_r <= remain_r - 17'd1;
                            nonce_r  <= nonce_r + 32'd1;
                            state_r  <= ST_LOAD;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end else begin
                        state_r <= ST_OUT;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    out_valid_r <= 1'b0;
                    done_r      <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign done      = done_r;
    assign out_nonce = out_nonce_r;
    assign out_hash  = out_hash_r;

endmodule

// File: doc/sha256_nonce_sweep.md
SHA256_NONCE_SWEEP -- requirements
Module: sha256_nonce_sweep

Interface
REQ-001 SHALL have parameter NUM_NONCES, default 16, number of consecutive nonces hashed per start (1..65536).
REQ-002 SHALL have parameter DOUBLE_HASH, default 1, where 0 means a single second-block compression and 1 means SHA-256d (a second SHA-256 over the 256-bit digest).
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port reset_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, one-cycle request; sampled only in IDLE.
REQ-006 SHALL have port midstate, input, 8x32, digest of header block 1 (H0..H7).
REQ-007 SHALL have port tail, input, 3x32, header words 16..18 (block-2 W0..W2).
REQ-008 SHALL have port nonce_base, input, 32, first nonce word (block-2 W3).
REQ-009 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-010 SHALL have port out_valid, output, 1, result available.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port out_nonce, output, 32, nonce of the current result.
REQ-013 SHALL have port out_hash, output, 256, result digest with H0 in bits [255:224].
REQ-014 SHALL have port done, output, 1, one-cycle pulse at the end of the sweep.

Function
REQ-015 SHALL register midstate, tail and nonce_base on the start edge; later input changes SHALL have no effect until the next IDLE.
REQ-016 SHALL build block 2 as W0..W2 = tail, W3 = nonce, W4 = 0x80000000, W5..W14 = 0, W15 = 0x00000280.
REQ-017 SHALL build the DOUBLE_HASH block as W0..W7 = pass-1 digest, W8 = 0x80000000, W9..W14 = 0, W15 = 0x00000100, with the standard SHA-256 IV as chaining value.
REQ-018 SHALL implement states IDLE, LOAD, ROUND, FINAL, LOAD2, ROUND2, FINAL2, OUT and DONE.
REQ-019 SHALL transition IDLE->LOAD on start, LOAD->ROUND after one cycle, ROUND->FINAL after 64 cycles (round t = 0..63, one per cycle), and FINAL->LOAD2 when DOUBLE_HASH = 1, else FINAL->OUT.
REQ-020 SHALL transition LOAD2->ROUND2->FINAL2->OUT with the same timing as LOAD->ROUND->FINAL.
REQ-021 SHALL compute the message schedule as a 16-word sliding window, producing W[t] for t >= 16 in the same cycle it is consumed, with no extra bubble cycles.
REQ-022 SHALL form FINAL digests as working variables plus chaining value, each word modulo 2^32.
REQ-023 SHALL assert out_valid exactly 66 edges (DOUBLE_HASH = 0) or 132 edges (DOUBLE_HASH = 1) after the accepting start edge, for the first nonce.
REQ-024 SHALL hold out_valid, out_nonce and out_hash stable in OUT until out_valid && out_ready.
REQ-025 SHALL, on acceptance, go to LOAD with nonce+1 (wrapping 0xFFFFFFFF->0x00000000) if results remain, else go to DONE.
REQ-026 SHALL make the per-nonce period 66 (or 132) cycles plus OUT wait cycles, with a minimum of 1 OUT cycle.
REQ-027 SHALL assert done for exactly the one DONE cycle, then return to IDLE; busy SHALL be low in IDLE only.
REQ-028 SHALL ignore start while busy, with no restart and no effect on the running sweep.
REQ-029 SHALL emit exactly NUM_NONCES results per start, in ascending nonce order.

Reset
REQ-030 SHALL, while reset_n is low, go to IDLE and clear busy, out_valid and done; out_hash, out_nonce and the nonce counter SHALL be 0.
REQ-031 SHALL abort a sweep on reset assertion mid-operation: no further out_valid, no done pulse, and new start accepted on the first edge after release.

Structure
REQ-032 SHALL place the K[0..63] table, IV constants, padding/length constants, state enum, and rotr/Sigma/ch/maj functions in a shared package sha256_pkg.
REQ-033 SHALL use one combinational sub-module sha256_round (one compression round plus one schedule step), shared by ROUND and ROUND2.

Verification
REQ-034 SHALL cover genesis: DOUBLE_HASH = 1, block-1 midstate of the Bitcoin genesis header, tail = header words 16..18, nonce_base = 0x1dac2b7c, NUM_NONCES = 1 -> out_hash = 0x6fe28c0a...00000000 (H7 = 0), out_valid 132 edges after start, then done.
REQ-035 SHALL cover a sweep: NUM_NONCES = 4, nonce_base = 0xFFFFFFFE, out_ready held high -> out_nonce = FFFFFFFE, FFFFFFFF, 00000000, 00000001, each digest matching the software model, with 1 done pulse.
REQ-036 SHALL cover backpressure: out_ready low for 20 cycles on result 2 -> out_valid and data stable, result 3 starts only after acceptance, count unchanged.
REQ-037 SHALL cover start while busy: a second start pulse at cycle 30 -> ignored; the same 4 results and a single done.
REQ-038 SHALL cover reset mid-operation: reset_n low during ROUND of nonce 1 -> busy = 0 and out_valid = 0 immediately, no done; a fresh start then yields the full correct sweep.
REQ-039 SHALL cover single mode: DOUBLE_HASH = 0 -> out_hash equals block-2 compression only, latency 66 edges.
